// File: rtl/dti_global_parameters.sv
// Shared encodings for the load/store unit: decode-stage memory op and size codes,
// trap cause codes and the LSU state type.
package dti_global_parameters;

  localparam logic [2:0] MEMORY_TYPE_NONE          = 3'd0;
  localparam logic [2:0] MEMORY_TYPE_LOAD          = 3'd1;
  localparam logic [2:0] MEMORY_TYPE_LOAD_UNSIGNED = 3'd2;
  localparam logic [2:0] MEMORY_TYPE_STORE         = 3'd3;
  localparam logic [2:0] MEMORY_TYPE_INVALID       = 3'd4;

  localparam logic [1:0] MEMOP_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEMOP_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEMOP_SIZE_WORD = 2'd2;

  localparam logic [5:0] CSR_CAUSE_NONE               = 6'd0;
  localparam logic [5:0] CSR_CAUSE_INVALID_INSTR      = 6'd2;
  localparam logic [5:0] CSR_CAUSE_LOAD_MISALIGNED    = 6'd4;
  localparam logic [5:0] CSR_CAUSE_LOAD_ACCESS_FAULT  = 6'd5;
  localparam logic [5:0] CSR_CAUSE_STORE_MISALIGNED   = 6'd6;
  localparam logic [5:0] CSR_CAUSE_STORE_ACCESS_FAULT = 6'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Any size code other than byte/half is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEMOP_SIZE_BYTE: return 1'b0;
      MEMOP_SIZE_HALF: return addr_lo[0];
      default:         return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering: byte enables, store data replication and
// load data shift/extension for a 32-bit little-endian data bus.
module riscv_lsu_align
  import dti_global_parameters::*;
(
  input  logic [1:0]  mem_size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = bus_rdata >> {addr_lo, 3'b000};
    be         = 4'b1111;
    lane_wdata = wdata;
    load_data  = shifted;
    case (mem_size)
      MEMOP_SIZE_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      MEMOP_SIZE_HALF: begin
        be         = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding data-bus access at a time, with alignment
// checking, lane steering and trap cause reporting on a one-cycle done pulse.
module riscv_lsu
  import dti_global_parameters::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  mem_op,
  input  logic [1:0]  mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic [31:0] rdata,
  output logic        done,
  output logic        exception,
  output logic [5:0]  exception_cause
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [5:0]  cause_q, cause_d;

  logic        op_is_store;
  logic        in_is_store;
  logic        op_accepted;
  logic [3:0]  be_w;
  logic [31:0] lane_wdata_w;
  logic [31:0] load_data_w;

  assign op_is_store = (op_q == MEMORY_TYPE_STORE);
  assign in_is_store = (mem_op == MEMORY_TYPE_STORE);
  assign op_accepted = (mem_op == MEMORY_TYPE_LOAD) || (mem_op == MEMORY_TYPE_LOAD_UNSIGNED) ||
                       (mem_op == MEMORY_TYPE_STORE) || (mem_op == MEMORY_TYPE_INVALID);

  riscv_lsu_align u_align (
    .mem_size    (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (op_q == MEMORY_TYPE_LOAD_UNSIGNED),
    .wdata       (wdata_q),
    .bus_rdata   (dbus_rdata),
    .be          (be_w),
    .lane_wdata  (lane_wdata_w),
    .load_data   (load_data_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= MEMORY_TYPE_NONE;
      size_q  <= MEMOP_SIZE_BYTE;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      cause_q <= CSR_CAUSE_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    op_d     = op_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    stall    = 1'b0;
    dbus_req = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush && op_accepted) begin
          stall   = 1'b1;
          addr_d  = addr;
          op_d    = mem_op;
          size_d  = mem_size;
          wdata_d = wdata;
          rdata_d = '0;
          if (mem_op == MEMORY_TYPE_INVALID) begin
            exc_d   = 1'b1;
            cause_d = CSR_CAUSE_INVALID_INSTR;
            state_d = RESP;
          end else if (is_misaligned(mem_size, addr[1:0])) begin
            exc_d   = 1'b1;
            cause_d = in_is_store ? CSR_CAUSE_STORE_MISALIGNED : CSR_CAUSE_LOAD_MISALIGNED;
            state_d = RESP;
          end else begin
            exc_d   = 1'b0;
            cause_d = CSR_CAUSE_NONE;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall    = 1'b1;
        dbus_req = 1'b1;
        if (dbus_gnt) begin
          state_d = WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Past the grant the bus owes us a response, so flush no longer applies.
        stall = 1'b1;
        if (dbus_rvalid) begin
          rdata_d = (dbus_err || op_is_store) ? 32'h0 : load_data_w;
          exc_d   = dbus_err;
          cause_d = !dbus_err ? CSR_CAUSE_NONE :
                    op_is_store ? CSR_CAUSE_STORE_ACCESS_FAULT : CSR_CAUSE_LOAD_ACCESS_FAULT;
          state_d = RESP;
        end
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are only driven while requesting so an idle bus reads all-zero.
  assign dbus_we         = dbus_req & op_is_store;
  assign dbus_addr       = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dbus_be         = dbus_req ? be_w : 4'b0000;
  assign dbus_wdata      = dbus_req ? lane_wdata_w : 32'h0;
  assign rdata           = rdata_q;
  assign exception       = done & exc_q;
  assign exception_cause = exception ? cause_q : CSR_CAUSE_NONE;

endmodule
